// File: rtl/gbc_pkg.sv
// Shared types and helpers for the grant burst controller.
package gbc_pkg;

   localparam int N_REQ = 4;
   localparam int IDX_W = $clog2(N_REQ);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } gbc_state_e;

   // Index of the highest set bit; 0 when the vector is empty.
   function automatic logic [IDX_W-1:0] onehot_hi_idx(input logic [N_REQ-1:0] vec);
      logic [IDX_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (vec[i]) idx = IDX_W'(i);
      end
      return idx;
   endfunction

   // More than one bit set.
   function automatic logic is_multi_hot(input logic [N_REQ-1:0] vec);
      return (vec & (vec - 1'b1)) != '0;
   endfunction

endpackage

// File: rtl/burst_beat_counter.sv
// Beat counter for one burst: holds the captured length and the current beat
// index. The counter stops at the captured length, so it cannot wrap.
module burst_beat_counter #(
   parameter int LEN_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [LEN_W-1:0] len,
   input  logic             advance,
   output logic [LEN_W-1:0] beat_cnt,
   output logic             beat_last
);

   logic [LEN_W-1:0] cnt_q, cnt_d;
   logic [LEN_W-1:0] len_q, len_d;

   // Load restarts at beat 0 with a new length; advance steps unless on the last beat.
   always_comb begin
      cnt_d = cnt_q;
      len_d = len_q;
      if (load) begin
         cnt_d = '0;
         len_d = len;
      end else if (advance && !beat_last) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Count and length registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         len_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         len_q <= len_d;
      end
   end

   assign beat_cnt  = cnt_q;
   assign beat_last = (cnt_q == len_q);

endmodule

// File: rtl/grant_burst_controller.sv
// Locks the arbiter's winner onto the shared resource for a len+1 beat burst,
// masks further requests while busy and pulses done at burst end.
//
//   state | meaning
//   IDLE  | mask open, waiting for a grant (only state that samples gnt_in)
//   BURST | owner locked, offering beats until the last one is accepted
//   DONE  | one cycle, done pulse on the owner's bit, mask still closed
module grant_burst_controller
   import gbc_pkg::*;
#(
   parameter int LEN_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [N_REQ-1:0]       gnt_in,
   input  logic [N_REQ*LEN_W-1:0] len_in,
   input  logic                   beat_ready,
   output logic [N_REQ-1:0]       req_mask,
   output logic [N_REQ-1:0]       owner,
   output logic                   busy,
   output logic                   beat_valid,
   output logic                   beat_last,
   output logic [LEN_W-1:0]       beat_cnt,
   output logic [N_REQ-1:0]       done,
   output logic                   err_multi
);

   gbc_state_e       state_q, state_d;
   logic [N_REQ-1:0] owner_q, owner_d;
   logic             err_q, err_d;
   logic             cnt_load;
   logic [LEN_W-1:0] cnt_len;
   logic             cnt_adv;
   logic             cnt_last;
   logic [IDX_W-1:0] gnt_idx;

   assign gnt_idx = onehot_hi_idx(gnt_in);

   // Next state, owner capture and counter load; DONE reloads a zero length to clear the count.
   always_comb begin
      state_d  = state_q;
      owner_d  = owner_q;
      err_d    = err_q;
      cnt_load = 1'b0;
      cnt_len  = '0;
      case (state_q)
         IDLE: begin
            if (gnt_in != '0) begin
               state_d  = BURST;
               owner_d  = N_REQ'(1) << gnt_idx;
               err_d    = err_q | is_multi_hot(gnt_in);
               cnt_load = 1'b1;
               cnt_len  = len_in[gnt_idx*LEN_W +: LEN_W];
            end
         end
         BURST: begin
            if (beat_ready && cnt_last) state_d = DONE;
         end
         DONE: begin
            state_d  = IDLE;
            owner_d  = '0;
            cnt_load = 1'b1;
         end
         default: begin
            state_d  = IDLE;
            owner_d  = '0;
            cnt_load = 1'b1;
         end
      endcase
   end

   // State, owner and sticky error registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         err_q   <= err_d;
      end
   end

   assign cnt_adv = (state_q == BURST) && beat_ready;

   burst_beat_counter #(.LEN_W(LEN_W)) u_beat_counter (
      .clk       (clk),
      .rst       (rst),
      .load      (cnt_load),
      .len       (cnt_len),
      .advance   (cnt_adv),
      .beat_cnt  (beat_cnt),
      .beat_last (cnt_last)
   );

   assign req_mask   = (state_q == IDLE) ? '1 : '0;
   assign owner      = owner_q;
   assign busy       = (state_q != IDLE);
   assign beat_valid = (state_q == BURST);
   assign beat_last  = beat_valid && cnt_last;
   assign done       = (state_q == DONE) ? owner_q : '0;
   assign err_multi  = err_q;

endmodule

// File: tb/tb_grant_burst_controller.sv
module tb_grant_burst_controller;

   logic        clk;
   logic        rst;
   logic [3:0]  gnt_in;
   logic [15:0] len_in;
   logic        beat_ready;
   logic [3:0]  req_mask;
   logic [3:0]  owner;
   logic        busy;
   logic        beat_valid;
   logic        beat_last;
   logic [3:0]  beat_cnt;
   logic [3:0]  done;
   logic        err_multi;

   grant_burst_controller #(.LEN_W(4)) dut (
      .clk        (clk),
      .rst        (rst),
      .gnt_in     (gnt_in),
      .len_in     (len_in),
      .beat_ready (beat_ready),
      .req_mask   (req_mask),
      .owner      (owner),
      .busy       (busy),
      .beat_valid (beat_valid),
      .beat_last  (beat_last),
      .beat_cnt   (beat_cnt),
      .done       (done),
      .err_multi  (err_multi)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  gnt;
      logic [3:0]  len;
      logic [15:0] ready;
      logic        noise;
      logic [3:0]  exp_owner;
      logic        exp_err;
   } vec_t;

   typedef struct {
      logic [3:0] cnt;
      logic       last;
   } beat_t;

   vec_t  vecs[6];
   beat_t exp_q[$];
   int    total = 0;
   int    bad   = 0;

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_vec(input int vi, input vec_t v);
      int   idx;
      int   occ;
      int   stalls;
      int   k;
      bit   got_done;
      beat_t e;
      idx = 0;
      for (int f = 0; f < 4; f++) if (v.exp_owner[f]) idx = f;
      for (int f = 0; f < 4; f++) len_in[f*4 +: 4] = (f == idx) ? v.len : 4'(v.len + f + 5);
      exp_q.delete();
      for (int i = 0; i <= int'(v.len); i++) begin
         e.cnt  = 4'(i);
         e.last = (i == int'(v.len));
         exp_q.push_back(e);
      end
      gnt_in = v.gnt;
      beat_ready = 1'b1;
      step();
      gnt_in = v.noise ? 4'b0001 : 4'b0000;
      chk($sformatf("v%0d_owner", vi), int'(owner), int'(v.exp_owner));
      chk($sformatf("v%0d_mask_closed", vi), int'(req_mask), 0);
      chk($sformatf("v%0d_err", vi), int'(err_multi), int'(v.exp_err));
      occ = 1;
      stalls = 0;
      k = 0;
      got_done = 0;
      for (int c = 0; c < 64 && !got_done; c++) begin
         if (c > 0) step();
         occ++;
         if (v.noise) begin
            gnt_in = 4'b0001;
            len_in = 16'($urandom);
         end
         if (done != 4'b0000) begin
            got_done = 1;
            chk($sformatf("v%0d_done", vi), int'(done), int'(v.exp_owner));
            chk($sformatf("v%0d_done_valid", vi), int'(beat_valid), 0);
            chk($sformatf("v%0d_left_beats", vi), exp_q.size(), 0);
            chk($sformatf("v%0d_occupancy", vi), occ, int'(v.len) + 3 + stalls);
         end else begin
            if (!beat_valid || exp_q.size() == 0) begin
               chk($sformatf("v%0d_unexpected_state", vi), int'(beat_valid), int'(exp_q.size() != 0));
               break;
            end
            if (int'(owner) != int'(v.exp_owner))
               chk($sformatf("v%0d_owner_hold", vi), int'(owner), int'(v.exp_owner));
            beat_ready = v.ready[k % 16];
            k++;
            if (beat_ready) begin
               e = exp_q.pop_front();
               chk($sformatf("v%0d_cnt", vi), int'(beat_cnt), int'(e.cnt));
               chk($sformatf("v%0d_last", vi), int'(beat_last), int'(e.last));
            end else begin
               stalls++;
               chk($sformatf("v%0d_cnt_hold", vi), int'(beat_cnt), int'(exp_q[0].cnt));
            end
         end
      end
      if (!got_done) chk($sformatf("v%0d_done_timeout", vi), 0, 1);
      gnt_in = 4'b0000;
      beat_ready = 1'b1;
      step();
      chk($sformatf("v%0d_done_pulse_len", vi), int'(done), 0);
      chk($sformatf("v%0d_mask_open", vi), int'(req_mask), 15);
      chk($sformatf("v%0d_idle_owner", vi), int'(owner), 0);
      chk($sformatf("v%0d_idle_cnt", vi), int'(beat_cnt), 0);
      step();
      chk($sformatf("v%0d_stay_idle", vi), int'(busy), 0);
   endtask

   initial begin
      vecs[0] = '{gnt: 4'b0010, len: 4'd3,  ready: 16'hFFFF, noise: 1'b0, exp_owner: 4'b0010, exp_err: 1'b0};
      vecs[1] = '{gnt: 4'b1000, len: 4'd0,  ready: 16'hFFFF, noise: 1'b0, exp_owner: 4'b1000, exp_err: 1'b0};
      vecs[2] = '{gnt: 4'b0001, len: 4'd2,  ready: 16'hFFF9, noise: 1'b0, exp_owner: 4'b0001, exp_err: 1'b0};
      vecs[3] = '{gnt: 4'b0100, len: 4'd15, ready: 16'hFFFF, noise: 1'b1, exp_owner: 4'b0100, exp_err: 1'b0};
      vecs[4] = '{gnt: 4'b0110, len: 4'd5,  ready: 16'hB7FF, noise: 1'b0, exp_owner: 4'b0100, exp_err: 1'b1};
      vecs[5] = '{gnt: 4'b0001, len: 4'd1,  ready: 16'hFFFF, noise: 1'b1, exp_owner: 4'b0001, exp_err: 1'b1};

      rst = 1'b1;
      gnt_in = 4'b0000;
      len_in = 16'h0000;
      beat_ready = 1'b0;
      #2;
      chk("rst_mask", int'(req_mask), 15);
      chk("rst_owner", int'(owner), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_last", int'(beat_last), 0);
      chk("rst_err", int'(err_multi), 0);
      step();
      rst = 1'b0;
      step();
      chk("idle_no_grant", int'(busy), 0);

      for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

      // Reset in the middle of a len=7 burst, between clock edges.
      len_in = 16'h7000;
      gnt_in = 4'b1000;
      beat_ready = 1'b1;
      step();
      gnt_in = 4'b0000;
      for (int c = 0; c < 10 && beat_cnt != 4'd2; c++) step();
      chk("mid_cnt_reached", int'(beat_cnt), 2);
      #2;
      rst = 1'b1;
      #1;
      chk("mid_rst_owner", int'(owner), 0);
      chk("mid_rst_busy", int'(busy), 0);
      chk("mid_rst_valid", int'(beat_valid), 0);
      chk("mid_rst_last", int'(beat_last), 0);
      chk("mid_rst_cnt", int'(beat_cnt), 0);
      chk("mid_rst_done", int'(done), 0);
      chk("mid_rst_err", int'(err_multi), 0);
      chk("mid_rst_mask", int'(req_mask), 15);
      step();
      step();
      rst = 1'b0;
      for (int c = 0; c < 4; c++) begin
         step();
         if (done != 4'b0000) chk("post_rst_done", int'(done), 0);
         if (busy) chk("post_rst_busy", int'(busy), 0);
      end
      chk("post_rst_mask", int'(req_mask), 15);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
